// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, start-edge detect, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop plus the parity_err output.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_next;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    data_next;
  logic          valid_next, ferr_next, busy_next;
  logic          start_edge, tick;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_next, perr_next;
`endif

  assign start_edge = prev & ~sync2;
  assign tick       = (cnt == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt - 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift;
    data_next  = rx_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    perr_next    = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Requires a 1->0 transition, so a line stuck low never opens a frame.
        if (start_edge) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!sync2) begin
            state_next = DATA;
            cnt_next   = FULL_LOAD;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = FULL_LOAD;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {sync2, shift[7:1]};
          cnt_next   = FULL_LOAD;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_next = ^{shift, sync2};
          state_next   = STOP;
          cnt_next     = FULL_LOAD;
        end
      end
`endif
      STOP: begin
        // Leaving mid-stop-bit lets a start edge on the next bit boundary be caught.
        if (tick) begin
          state_next = IDLE;
          cnt_next   = FULL_LOAD;
          if (sync2) begin
            data_next  = shift;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_next = par_bad;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = FULL_LOAD;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= IDLE;
      cnt       <= FULL_LOAD;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      prev      <= sync2;
      state     <= state_next;
      cnt       <= cnt_next;
      bit_cnt   <= bit_next;
      shift     <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      rx_busy   <= busy_next;
      frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_next;
      parity_err <= perr_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; frames are bit-banged onto rx_in.
// Parity scenario is built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAT_NOM = 2 + (CPB * 19) / 2 + PAR_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  time t_fall  = 0;
  time t_valid = 0;
  byte unsigned exp_q[$];
  bit           exp_pe_q[$];
  byte unsigned mon_e;
  bit           mon_pe;

  uart_rx #(.CLK_FREQ(1600000), .BAUD_RATE(100000)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy),
    .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every rx_valid pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        n_valid++;
        t_valid = $time;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid got=%h expected=none", rx_data);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_pe = exp_pe_q.pop_front();
          if (rx_data !== mon_e) begin
            bad++;
            $display("FAIL rx_data got=%h expected=%h", rx_data, mon_e);
          end
`ifdef UART_RX_PARITY_EN
          total++;
          if (parity_err !== mon_pe) begin
            bad++;
            $display("FAIL parity_err got=%b expected=%b data=%h", parity_err, mon_pe, mon_e);
          end
`endif
        end
        total++;
        if (rx_busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_with_valid got=%b expected=0", rx_busy);
        end
      end
      if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    if (stop) begin
      exp_q.push_back(b);
      exp_pe_q.push_back(!par_ok);
    end
    t_fall = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^b : ~^b);
`endif
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (3 * CPB) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got=%0d_pending expected=0", name, exp_q.size());
      exp_q.delete();
      exp_pe_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
`ifdef UART_RX_PARITY_EN
    if ({rx_data, rx_valid, rx_busy, frame_err, parity_err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b expected=00/0000",
               rx_data, rx_valid, rx_busy, frame_err, parity_err);
    end
`else
    if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b%b%b expected=00/000",
               rx_data, rx_valid, rx_busy, frame_err);
    end
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int  v0, f0;
    longint lat;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h55, 1'b1, 1'b1);
    drain("single");
    total++;
    if (n_valid != v0 + 1) begin
      bad++;
      $display("FAIL single_count got=%0d expected=%0d", n_valid - v0, 1);
    end
    total++;
    if (n_ferr != f0) begin
      bad++;
      $display("FAIL single_ferr got=%0d expected=0", n_ferr - f0);
    end
    lat = longint'((t_valid - t_fall) / 10);
    total++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 2) begin
      bad++;
      $display("FAIL single_latency got=%0d expected=%0d", lat, LAT_NOM);
    end
    total++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h55) begin
      bad++;
      $display("FAIL single_hold got=%b/%h expected=0/55", rx_busy, rx_data);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    drain("b2b");
    total++;
    if (n_valid != v0 + 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d expected=2", n_valid - v0);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, hi;
    v0 = n_valid;
    f0 = n_ferr;
    hi = 0;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (rx_busy) hi++;
    end
    total++;
    if (hi < CPB / 2 - 2 || hi > CPB / 2 + 2) begin
      bad++;
      $display("FAIL glitch_busy_cycles got=%0d expected=%0d", hi, CPB / 2);
    end
    total++;
    if (rx_busy !== 1'b0 || n_valid != v0 || n_ferr != f0) begin
      bad++;
      $display("FAIL glitch_quiet got=%b/%0d/%0d expected=0/0/0", rx_busy, n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_frame_err;
    int v0, f0, hi;
    v0 = n_valid;
    f0 = n_ferr;
    hi = 0;
    send_frame(8'hFF, 1'b0, 1'b1);
    rx_in = 1'b0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (rx_busy) hi++;
    end
    total++;
    if (n_ferr != f0 + 1) begin
      bad++;
      $display("FAIL ferr_count got=%0d expected=1", n_ferr - f0);
    end
    total++;
    if (rx_data !== 8'h3C) begin
      bad++;
      $display("FAIL ferr_data_hold got=%h expected=3c", rx_data);
    end
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL break_busy got=%0d_cycles expected=0", hi);
    end
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b1);
    drain("after_break");
    total++;
    if (n_valid != v0 + 1 || n_ferr != f0 + 1) begin
      bad++;
      $display("FAIL after_break_counts got=%0d/%0d expected=1/1", n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_reset_midframe;
    int v0, f0;
    logic [7:0] ab;
    v0 = n_valid;
    f0 = n_ferr;
    ab = 8'hC6;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(ab[i]);
    rx_in = ab[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    rx_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'h000) begin
        bad++;
        $display("FAIL midreset_outputs got=%h/%b%b%b expected=00/000",
                 rx_data, rx_valid, rx_busy, frame_err);
      end
    end
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++;
    if (n_valid != v0 || n_ferr != f0 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_silent got=%0d/%0d/%b expected=0/0/0", n_valid - v0, n_ferr - f0, rx_busy);
    end
    send_frame(8'h81, 1'b1, 1'b1);
    drain("post_reset");
    total++;
    if (n_valid != v0 + 1) begin
      bad++;
      $display("FAIL post_reset_count got=%0d expected=1", n_valid - v0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0, v0;
    p0 = n_perr;
    v0 = n_valid;
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    drain("parity");
    total++;
    if (n_perr != p0 + 1 || n_valid != v0 + 2) begin
      bad++;
      $display("FAIL parity_counts got=%0d/%0d expected=1/2", n_perr - p0, n_valid - v0);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
